// File: rtl/sync_ram_clr.sv
// Single-port synchronous RAM with byte enables, write-first read-back and an
// automatic zeroing sweep that runs after reset and on a clear request.
module sync_ram_clr #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 32768
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     d,
    input  logic [ADDR_W-1:0]     a,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  re,
    input  logic                  we,
    input  logic                  clr,
    output logic [DATA_W-1:0]     q,
    output logic                  rvalid,
    output logic                  err,
    output logic                  busy
);

    localparam int LANES = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                in_range_s;
    logic                sweep_last_s;
    logic [CNT_W-1:0]    idx_s;
    logic [DATA_W-1:0]   old_word_s;
    logic [DATA_W-1:0]   merged_s;
    logic                mem_we_s;
    logic [CNT_W-1:0]    mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_s;

    // Replace the byte lanes selected by en with new_w, keep the rest of old_w.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [LANES-1:0]  en
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (en[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // One extra address bit so the range test cannot wrap when DEPTH == 2**ADDR_W.
    assign in_range_s   = ({1'b0, a} < (ADDR_W+1)'(DEPTH));
    assign sweep_last_s = (cnt_q == CNT_W'(DEPTH - 1));
    assign idx_s        = a[CNT_W-1:0];
    assign old_word_s   = mem[idx_s];
    assign merged_s     = merge_lanes(old_word_s, d, be);

    // State, sweep counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= {CNT_W{1'b0}};
            q_q      <= {DATA_W{1'b0}};
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    // Storage array: single write port shared by the sweep and user writes.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Next-state and sweep counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (sweep_last_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_CLEAR;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Array write port, read data and status pulses.
    always_comb begin
        q_d         = q_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = cnt_q;
        mem_wdata_s = {DATA_W{1'b0}};
        busy_d      = (state_d == ST_CLEAR);
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = cnt_q;
                mem_wdata_s = {DATA_W{1'b0}};
            end
            ST_IDLE: begin
                // A clear request wins over any access presented alongside it.
                if (clr) begin
                    mem_we_s = 1'b0;
                end else if (re || we) begin
                    if (in_range_s) begin
                        if (we) begin
                            mem_we_s    = 1'b1;
                            mem_addr_s  = idx_s;
                            mem_wdata_s = merged_s;
                        end else begin
                            mem_we_s = 1'b0;
                        end
                        if (re) begin
                            q_d      = we ? merged_s : old_word_s;
                            rvalid_d = 1'b1;
                        end else begin
                            rvalid_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    assign q      = q_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sync_ram_clr.sv
// Directed bench for sync_ram_clr with DATA_W=32, ADDR_W=8, DEPTH=16.
module tb_sync_ram_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d;
    logic [7:0]  a;
    logic [3:0]  be;
    logic        re, we, clr;
    logic [31:0] q;
    logic        rvalid, err, busy;

    int n_tests = 0;
    int n_fail  = 0;

    sync_ram_clr #(.DATA_W(32), .ADDR_W(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .d(d), .a(a), .be(be), .re(re), .we(we),
        .clr(clr), .q(q), .rvalid(rvalid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for one edge, sample just after the edge, then drop it.
    task automatic drive(input logic r, input logic w, input logic c, input logic [7:0] ad,
                         input logic [31:0] dd, input logic [3:0] bb);
        re = r; we = w; clr = c; a = ad; d = dd; be = bb;
        @(posedge clk);
        #1;
        re = 1'b0; we = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_sweep(input string tag, input int exp_edges);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(n), 32'(exp_edges));
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(i), 32'h0, 4'h0);
            chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
            chk({tag, "_q"}, q, 32'h0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; re = 1'b0; we = 1'b0; clr = 1'b0; a = 8'h0; d = 32'h0; be = 4'h0;
        #2 rst = 1'b0;
        #1;
        chk("rst_q", q, 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_sweep("init_sweep_edges", 16);
        chk("idle_busy", 32'(busy), 32'd0);
        read_all_zero("init_rd");

        // Byte-lane merge.
        drive(1'b0, 1'b1, 1'b0, 8'd3, 32'hAABBCCDD, 4'b1111);
        chk("wr_only_rvalid", 32'(rvalid), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 8'd3, 32'h11223344, 4'b0101);
        drive(1'b1, 1'b0, 1'b0, 8'd3, 32'h0, 4'h0);
        chk("merge_rvalid", 32'(rvalid), 32'd1);
        chk("merge_q", q, 32'hAA22CC44);

        // Write-first read-back.
        drive(1'b1, 1'b1, 1'b0, 8'd5, 32'h0000005A, 4'b0001);
        chk("wf_rvalid", 32'(rvalid), 32'd1);
        chk("wf_q", q, 32'h0000005A);
        drive(1'b1, 1'b0, 1'b0, 8'd5, 32'h0, 4'h0);
        chk("wf_reread", q, 32'h0000005A);

        // Zero byte enables return the unmodified word.
        drive(1'b1, 1'b1, 1'b0, 8'd3, 32'hFFFFFFFF, 4'b0000);
        chk("be0_q", q, 32'hAA22CC44);
        drive(1'b0, 1'b0, 1'b0, 8'd5, 32'h0, 4'h0);
        chk("hold_q", q, 32'hAA22CC44);
        chk("hold_rvalid", 32'(rvalid), 32'd0);

        // Out-of-range accesses.
        drive(1'b1, 1'b0, 1'b0, 8'd16, 32'h0, 4'h0);
        chk("oor_rd_err", 32'(err), 32'd1);
        chk("oor_rd_rvalid", 32'(rvalid), 32'd0);
        chk("oor_rd_q", q, 32'hAA22CC44);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
        chk("err_pulse_end", 32'(err), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 8'd200, 32'hDEADBEEF, 4'hF);
        chk("oor_wr_err", 32'(err), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 8'd8, 32'h0, 4'h0);
        chk("oor_wr_no_alias", q, 32'h0);
        chk("oor_wr_err_clear", 32'(err), 32'd0);

        // Fill, then clear with a colliding write.
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, 8'(i), 32'h10000001 + 32'(i), 4'hF);
        drive(1'b1, 1'b0, 1'b0, 8'd7, 32'h0, 4'h0);
        chk("fill_q", q, 32'h10000008);
        drive(1'b1, 1'b1, 1'b1, 8'd2, 32'h12345678, 4'hF);
        chk("clr_rvalid", 32'(rvalid), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        re = 1'b1; we = 1'b1; a = 8'd1; d = 32'hFFFFFFFF; be = 4'hF;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            chk("sweep_rvalid", 32'(rvalid), 32'd0);
        end
        re = 1'b0; we = 1'b0;
        chk("clr_sweep_edges", 32'(n), 32'd16);
        chk("sweep_q_held", q, 32'h10000008);
        read_all_zero("clr_rd");

        // Reset in the middle of a sweep restarts it from word 0.
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, 8'(i), 32'h20000001 + 32'(i), 4'hF);
        drive(1'b0, 1'b0, 1'b1, 8'd0, 32'h0, 4'h0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_q", q, 32'h0);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_sweep("midrst_sweep_edges", 16);
        read_all_zero("midrst_rd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
